// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters predicting two sequential fetch slots.
// Build option: define BP_DUAL_SLOT_EN to enable slot-2 (Fetch_PC+4) prediction.
module branch_predictor #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Fetch_PC,
    input  logic        Commit,
    input  logic [31:0] Com_PC,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_PC,
    output logic        pre_Take,
    output logic        Pre_Inst1_Branch,
    output logic        Pre_Inst2_Branch,
    output logic [31:0] pre_PC
);
    localparam int N  = 1 << IDX_W;
    localparam int TW = 30 - IDX_W;

    logic [N-1:0]  valid_q, valid_d;
    logic [TW-1:0] tag_q [N];
    logic [TW-1:0] tag_d [N];
    logic [31:0]   tgt_q [N];
    logic [31:0]   tgt_d [N];
    logic [1:0]    cnt_q [N];
    logic [1:0]    cnt_d [N];

    logic [IDX_W-1:0] idx1, ci;
    logic             tk1, chit;
    logic [31:0]      seq_pc;
    logic             unused_bits;

    assign idx1   = Fetch_PC[IDX_W+1:2];
    assign ci     = Com_PC[IDX_W+1:2];
    assign seq_pc = Fetch_PC + 32'd8;
    assign tk1    = valid_q[idx1] && tag_q[idx1] == Fetch_PC[31:IDX_W+2] && cnt_q[idx1][1];
    assign chit   = valid_q[ci] && tag_q[ci] == Com_PC[31:IDX_W+2];

`ifdef BP_DUAL_SLOT_EN
    logic [31:0]      pc2;
    logic [IDX_W-1:0] idx2;
    logic             tk2;
    assign pc2  = Fetch_PC + 32'd4;
    assign idx2 = pc2[IDX_W+1:2];
    assign tk2  = valid_q[idx2] && tag_q[idx2] == pc2[31:IDX_W+2] && cnt_q[idx2][1];
    assign unused_bits = ^{Fetch_PC[1:0], Com_PC[1:0], pc2[1:0]};
    // Slot 1 has priority; slot 2 only redirects when slot 1 falls through
    always_comb begin
        Pre_Inst1_Branch = tk1;
        Pre_Inst2_Branch = tk2 && !tk1;
        pre_Take         = tk1 || tk2;
        pre_PC           = tk1 ? tgt_q[idx1] : tk2 ? tgt_q[idx2] : seq_pc;
    end
`else
    assign unused_bits = ^{Fetch_PC[1:0], Com_PC[1:0]};
    // Single-slot prediction: only slot 1 can redirect fetch
    always_comb begin
        Pre_Inst1_Branch = tk1;
        Pre_Inst2_Branch = 1'b0;
        pre_Take         = tk1;
        pre_PC           = tk1 ? tgt_q[idx1] : seq_pc;
    end
`endif

    // Commit-time training: adjust counter on hit, allocate weakly-taken on taken miss
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (Commit && chit) begin
            cnt_d[ci] = Branch_taken ? ((cnt_q[ci] == 2'd3) ? 2'd3 : cnt_q[ci] + 2'd1)
                                     : ((cnt_q[ci] == 2'd0) ? 2'd0 : cnt_q[ci] - 2'd1);
            if (Branch_taken) tgt_d[ci] = Branch_PC;
        end else if (Commit && Branch_taken) begin
            valid_d[ci] = 1'b1;
            tag_d[ci]   = Com_PC[31:IDX_W+2];
            tgt_d[ci]   = Branch_PC;
            cnt_d[ci]   = 2'd2;
        end
    end

    // BTB storage; reset wipes every entry including any update on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= 2'd1;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scoreboard bench for branch_predictor (IDX_W=4).
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] Fetch_PC = 32'h100;
    logic        Commit = 1'b0;
    logic [31:0] Com_PC = '0;
    logic        Branch_taken = 1'b0;
    logic [31:0] Branch_PC = '0;
    logic        pre_Take, Pre_Inst1_Branch, Pre_Inst2_Branch;
    logic [31:0] pre_PC;

`ifdef BP_DUAL_SLOT_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [34:0] exp;
    } exp_t;

    exp_t q[$];
    logic probe = 1'b0;
    int   checks = 0;
    int   failures = 0;

    branch_predictor #(.IDX_W(4)) dut (
        .clk(clk), .rst(rst), .Fetch_PC(Fetch_PC), .Commit(Commit), .Com_PC(Com_PC),
        .Branch_taken(Branch_taken), .Branch_PC(Branch_PC), .pre_Take(pre_Take),
        .Pre_Inst1_Branch(Pre_Inst1_Branch), .Pre_Inst2_Branch(Pre_Inst2_Branch), .pre_PC(pre_PC)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the queued expectation for each probed cycle
    always @(negedge clk) begin
        if (probe) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL no_expectation got take/i1/i2/pc=%h", {pre_Take, Pre_Inst1_Branch, Pre_Inst2_Branch, pre_PC});
            end else begin
                exp_t e;
                logic [34:0] got;
                e = q.pop_front();
                got = {pre_Take, Pre_Inst1_Branch, Pre_Inst2_Branch, pre_PC};
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s take/i1/i2/pc got=%b/%b/%b/%h exp=%b/%b/%b/%h", e.name,
                             got[34], got[33], got[32], got[31:0], e.exp[34], e.exp[33], e.exp[32], e.exp[31:0]);
                end
            end
        end
    end

    task automatic look(input string name, input logic [31:0] pc, input bit e1, input bit e2, input logic [31:0] epc);
        exp_t e;
        Fetch_PC = pc;
        e.name = name;
        e.exp  = {e1 | e2, e1, e2, epc};
        q.push_back(e);
        probe = 1'b1;
        @(posedge clk);
        #1 probe = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        Commit = 1'b1; Com_PC = pc; Branch_taken = tk; Branch_PC = tgt;
        @(posedge clk);
        #1 Commit = 1'b0; Branch_taken = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        look("reset", 32'h100, 0, 0, 32'h108);
        look("empty_wrap", 32'hFFFFFFFC, 0, 0, 32'h4);
        commit(32'h100, 1, 32'h40);
        look("alloc", 32'h100, 1, 0, 32'h40);
        look("slot2", 32'hFC, 0, DUAL, DUAL ? 32'h40 : 32'h104);
        commit(32'h100, 0, 32'h0);
        look("cnt1", 32'h100, 0, 0, 32'h108);
        commit(32'h100, 0, 32'h0);
        look("cnt0", 32'h100, 0, 0, 32'h108);
        commit(32'h100, 1, 32'h40);
        look("cnt0_to_1", 32'h100, 0, 0, 32'h108);
        commit(32'h100, 1, 32'h80);
        look("cnt2_newtgt", 32'h100, 1, 0, 32'h80);
        commit(32'h100, 1, 32'h80);
        commit(32'h100, 1, 32'h80);
        commit(32'h100, 0, 32'h999);
        look("sat3_then_dec", 32'h100, 1, 0, 32'h80);
        commit(32'h140, 1, 32'h300);
        look("alias_old_miss", 32'h100, 0, 0, 32'h108);
        look("alias_new_hit", 32'h140, 1, 0, 32'h300);
        commit(32'h100, 0, 32'h999);
        look("miss_nt_nochange", 32'h140, 1, 0, 32'h300);
        Commit = 1'b0; Com_PC = 32'h100; Branch_taken = 1'b1; Branch_PC = 32'h777;
        look("commit0_nochange", 32'h100, 0, 0, 32'h108);
        Branch_taken = 1'b0;
        Commit = 1'b1; Com_PC = 32'h200; Branch_taken = 1'b1; Branch_PC = 32'h444;
        look("no_bypass", 32'h200, 0, 0, 32'h208);
        Commit = 1'b0; Branch_taken = 1'b0;
        look("after_update", 32'h200, 1, 0, 32'h444);
        commit(32'h0, 1, 32'h500);
        look("wrap_slot2", 32'hFFFFFFFC, 0, DUAL, DUAL ? 32'h500 : 32'h4);
        commit(32'hFC, 1, 32'h600);
        commit(32'h100, 1, 32'h700);
        look("slot1_priority", 32'hFC, 1, 0, 32'h600);
        look("slot2_realloc", 32'hF8, 0, DUAL, DUAL ? 32'h600 : 32'h100);
        Commit = 1'b1; Com_PC = 32'h300; Branch_taken = 1'b1; Branch_PC = 32'h888;
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1; Commit = 1'b0; Branch_taken = 1'b0;
        look("midreset_dropped", 32'h300, 0, 0, 32'h308);
        look("midreset_cleared", 32'hFC, 0, 0, 32'h104);
        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
